// File: rtl/ct_idu_is_aiq_lch_rdy_ext.sv
// Per-entry launch-ready tracker for AIQ entries: one ready bit per forwarding
// pipe, loaded at dispatch or from a sibling create port, with speculative
// launch cancel and a delayed re-arm countdown per bit.

// One launch-ready bit and its re-arm countdown.
module ct_idu_is_aiq_lch_rdy_bit #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld,
    input  logic             dp_load,
    input  logic             dp_val,
    input  logic             cr_load,
    input  logic             cr_val,
    input  logic             cancel,
    input  logic             rearm,
    input  logic [CNT_W-1:0] dly,
    output logic             rdy,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;

    // Priority: dispatch load, create load, invalid entry, cancel, re-arm, countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy <= 1'b0;
            cnt <= '0;
        end else if (dp_load) begin
            rdy <= dp_val;
            cnt <= '0;
        end else if (vld && cr_load) begin
            rdy <= cr_val;
            cnt <= '0;
        end else if (!vld) begin
            cnt <= '0;
        end else if (cancel) begin
            // a re-arm of the same bit in the same cycle is dropped
            rdy <= 1'b0;
            cnt <= '0;
        end else if (rearm) begin
            if (dly == '0) begin
                rdy <= 1'b1;
                cnt <= '0;
            end else begin
                // reload even when a countdown is already running
                cnt <= dly;
            end
        end else if (cnt == CNT_W'(1)) begin
            rdy <= 1'b1;
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign pend = (cnt != '0);

endmodule

// Top: create-port arbitration, bypass read path and per-bit trackers.
module ct_idu_is_aiq_lch_rdy_ext #(
    parameter int WIDTH      = 2,
    parameter int CREATE_NUM = 2,
    parameter int CNT_W      = 2
) (
    input  logic                        y_clk,
    input  logic                        cpurst_b,
    input  logic                        vld,
    input  logic                        x_create_dp_en,
    input  logic [WIDTH-1:0]            x_create_lch_rdy,
    input  logic [CREATE_NUM-1:0]       x_create_entry,
    input  logic [CREATE_NUM-1:0]       y_create_dp_en,
    input  logic [CREATE_NUM*WIDTH-1:0] y_create_src_match,
    input  logic [WIDTH-1:0]            y_lch_cancel,
    input  logic [WIDTH-1:0]            y_lch_rearm,
    input  logic [CNT_W-1:0]            y_rearm_dly,
    output logic [WIDTH-1:0]            x_read_lch_rdy,
    output logic [WIDTH-1:0]            x_lch_pend
);

    logic [CREATE_NUM-1:0] create_en;
    logic                  any_create;
    logic [WIDTH-1:0]      sel_match;
    logic [WIDTH-1:0]      lch_rdy;

    assign create_en  = y_create_dp_en & x_create_entry;
    assign any_create = |create_en;

    // Lowest-index active create slot supplies the match vector (scan high to low
    // so the lowest index overwrites last).
    always_comb begin
        sel_match = '0;
        for (int k = CREATE_NUM - 1; k >= 0; k--) begin
            if (create_en[k]) sel_match = y_create_src_match[k*WIDTH +: WIDTH];
        end
    end

    // Bypass read: create data wins regardless of vld; otherwise mask cancelled pipes.
    always_comb begin
        if (any_create) x_read_lch_rdy = sel_match;
        else            x_read_lch_rdy = lch_rdy & ~(y_lch_cancel & {WIDTH{vld}});
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ct_idu_is_aiq_lch_rdy_bit #(.CNT_W(CNT_W)) u_bit (
            .clk     (y_clk),
            .rst_n   (cpurst_b),
            .vld     (vld),
            .dp_load (x_create_dp_en),
            .dp_val  (x_create_lch_rdy[i]),
            .cr_load (any_create),
            .cr_val  (sel_match[i]),
            .cancel  (y_lch_cancel[i]),
            .rearm   (y_lch_rearm[i]),
            .dly     (y_rearm_dly),
            .rdy     (lch_rdy[i]),
            .pend    (x_lch_pend[i])
        );
    end

endmodule

// File: tb/tb_ct_idu_is_aiq_lch_rdy_ext.sv
// Directed bench for ct_idu_is_aiq_lch_rdy_ext with a cycle-level reference model.
module tb_ct_idu_is_aiq_lch_rdy_ext;

    localparam int WIDTH = 2;
    localparam int CREATE_NUM = 2;
    localparam int CNT_W = 2;

    logic                        y_clk = 1'b0;
    logic                        cpurst_b;
    logic                        vld;
    logic                        x_create_dp_en;
    logic [WIDTH-1:0]            x_create_lch_rdy;
    logic [CREATE_NUM-1:0]       x_create_entry;
    logic [CREATE_NUM-1:0]       y_create_dp_en;
    logic [CREATE_NUM*WIDTH-1:0] y_create_src_match;
    logic [WIDTH-1:0]            y_lch_cancel;
    logic [WIDTH-1:0]            y_lch_rearm;
    logic [CNT_W-1:0]            y_rearm_dly;
    logic [WIDTH-1:0]            x_read_lch_rdy;
    logic [WIDTH-1:0]            x_lch_pend;

    int n_chk = 0;
    int n_fail = 0;

    ct_idu_is_aiq_lch_rdy_ext #(.WIDTH(WIDTH), .CREATE_NUM(CREATE_NUM), .CNT_W(CNT_W)) dut (
        .y_clk              (y_clk),
        .cpurst_b           (cpurst_b),
        .vld                (vld),
        .x_create_dp_en     (x_create_dp_en),
        .x_create_lch_rdy   (x_create_lch_rdy),
        .x_create_entry     (x_create_entry),
        .y_create_dp_en     (y_create_dp_en),
        .y_create_src_match (y_create_src_match),
        .y_lch_cancel       (y_lch_cancel),
        .y_lch_rearm        (y_lch_rearm),
        .y_rearm_dly        (y_rearm_dly),
        .x_read_lch_rdy     (x_read_lch_rdy),
        .x_lch_pend         (x_lch_pend)
    );

    always #5 y_clk = ~y_clk;

    // ---------------- reference model ----------------
    // m_left[i] = cycles remaining until bit i becomes ready again (0 = idle).
    bit m_rdy [WIDTH];
    int m_left[WIDTH];

    function automatic int winner();
        for (int k = 0; k < CREATE_NUM; k++)
            if (y_create_dp_en[k] && x_create_entry[k]) return k;
        return -1;
    endfunction

    function automatic bit match_bit(int k, int i);
        logic [CREATE_NUM*WIDTH-1:0] m;
        m = y_create_src_match;
        return m[k*WIDTH + i];
    endfunction

    always @(posedge y_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < WIDTH; i++) begin
                m_rdy[i]  <= 1'b0;
                m_left[i] <= 0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                int w;
                w = winner();
                if (x_create_dp_en) begin
                    m_rdy[i] <= x_create_lch_rdy[i];
                    m_left[i] <= 0;
                end else if (vld && w >= 0) begin
                    m_rdy[i] <= match_bit(w, i);
                    m_left[i] <= 0;
                end else if (!vld) begin
                    m_left[i] <= 0;
                end else if (y_lch_cancel[i]) begin
                    m_rdy[i] <= 1'b0;
                    m_left[i] <= 0;
                end else if (y_lch_rearm[i]) begin
                    if (int'(y_rearm_dly) == 0) m_rdy[i] <= 1'b1;
                    m_left[i] <= int'(y_rearm_dly);
                end else if (m_left[i] > 0) begin
                    if (m_left[i] == 1) m_rdy[i] <= 1'b1;
                    m_left[i] <= m_left[i] - 1;
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] exp_read();
        logic [WIDTH-1:0] r;
        int w;
        w = winner();
        for (int i = 0; i < WIDTH; i++) begin
            if (w >= 0) r[i] = match_bit(w, i);
            else        r[i] = m_rdy[i] && !(y_lch_cancel[i] && vld);
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] exp_pend();
        logic [WIDTH-1:0] p;
        for (int i = 0; i < WIDTH; i++) p[i] = (m_left[i] != 0);
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge y_clk) begin
        chk("model_read", 32'(x_read_lch_rdy), 32'(exp_read()));
        chk("model_pend", 32'(x_lch_pend), 32'(exp_pend()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge y_clk);
        #1;
    endtask

    task automatic clr_in();
        x_create_dp_en = 1'b0;
        x_create_lch_rdy = '0;
        x_create_entry = '0;
        y_create_dp_en = '0;
        y_create_src_match = '0;
        y_lch_cancel = '0;
        y_lch_rearm = '0;
        y_rearm_dly = '0;
    endtask

    // Literal expectation shortly after inputs settle.
    task automatic lit(input string name, input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] p);
        #1;
        chk({name, "_read"}, 32'(x_read_lch_rdy), 32'(r));
        chk({name, "_pend"}, 32'(x_lch_pend), 32'(p));
    endtask

    task automatic rearm0(input logic [CNT_W-1:0] d);
        y_lch_rearm = 2'b01;
        y_rearm_dly = d;
        step();
        clr_in();
    endtask

    task automatic cancel0();
        y_lch_cancel = 2'b01;
        step();
        clr_in();
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        x_create_dp_en = 1'b1;
        x_create_lch_rdy = v;
        step();
        clr_in();
    endtask

    initial begin
        clr_in();
        vld = 1'b0;
        cpurst_b = 1'b0;
        // dispatch held during reset must not load
        x_create_dp_en = 1'b1;
        x_create_lch_rdy = 2'b10;
        step();
        lit("in_reset", 2'b00, 2'b00);
        cpurst_b = 1'b1;
        step();
        lit("dp_load", 2'b10, 2'b00);
        clr_in();

        // both slots hit: slot0 wins on read and register
        vld = 1'b1;
        x_create_entry = 2'b11;
        y_create_dp_en = 2'b11;
        y_create_src_match = 4'b1001;
        lit("create_bypass", 2'b01, 2'b00);
        step();
        clr_in();
        lit("create_reg", 2'b01, 2'b00);

        // only slot1 active, entry invalid: bypass still shows, register holds
        vld = 1'b0;
        x_create_entry = 2'b11;
        y_create_dp_en = 2'b10;
        y_create_src_match = 4'b1001;
        lit("slot1_bypass", 2'b10, 2'b00);
        step();
        clr_in();
        lit("slot1_novld", 2'b01, 2'b00);
        vld = 1'b1;

        // cancel with vld
        load(2'b11);
        lit("load11", 2'b11, 2'b00);
        y_lch_cancel = 2'b01;
        lit("cancel_same", 2'b10, 2'b00);
        step();
        clr_in();
        lit("cancel_reg", 2'b10, 2'b00);

        // cancel with vld=0 is ignored
        load(2'b11);
        vld = 1'b0;
        y_lch_cancel = 2'b01;
        lit("cancel_novld", 2'b11, 2'b00);
        step();
        clr_in();
        lit("cancel_novld_reg", 2'b11, 2'b00);
        vld = 1'b1;

        // rearm dly=3
        cancel0();
        rearm0(2'd3);
        lit("rearm3_c1", 2'b10, 2'b01);
        step();
        lit("rearm3_c2", 2'b10, 2'b01);
        step();
        lit("rearm3_c3", 2'b10, 2'b01);
        step();
        lit("rearm3_done", 2'b11, 2'b00);

        // rearm dly=0
        cancel0();
        lit("cleared", 2'b10, 2'b00);
        rearm0(2'd0);
        lit("rearm0", 2'b11, 2'b00);

        // cancel + rearm same cycle mid-count
        cancel0();
        rearm0(2'd2);
        lit("cnt2", 2'b10, 2'b01);
        y_lch_cancel = 2'b01;
        y_lch_rearm = 2'b01;
        y_rearm_dly = 2'd2;
        step();
        clr_in();
        lit("cancel_rearm", 2'b10, 2'b00);
        step();
        step();
        lit("cancel_rearm_hold", 2'b10, 2'b00);

        // reload mid-count
        rearm0(2'd2);
        step();
        lit("cnt1", 2'b10, 2'b01);
        rearm0(2'd3);
        lit("reload3", 2'b10, 2'b01);
        step();
        step();
        lit("reload_c3", 2'b10, 2'b01);
        step();
        lit("reload_done", 2'b11, 2'b00);

        // dispatch mid-count clears countdown
        cancel0();
        rearm0(2'd3);
        load(2'b00);
        lit("dp_clear", 2'b00, 2'b00);
        step();
        step();
        lit("dp_clear_hold", 2'b00, 2'b00);

        // async reset mid-count
        load(2'b11);
        cancel0();
        rearm0(2'd3);
        step();
        lit("pre_rst", 2'b10, 2'b01);
        cpurst_b = 1'b0;
        lit("async_rst", 2'b00, 2'b00);
        step();
        cpurst_b = 1'b1;
        step();
        lit("post_rst", 2'b00, 2'b00);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
